// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose:
//   Instruction fetch front end. It keeps the program counter, sends one
//   fetch request at a time to instruction memory, and holds each returned
//   word in a one-entry output buffer. A one-entry skid register catches the
//   word that returns while the output buffer is full and stalled. Branch
//   redirects flush the output buffer and any fetch already in flight.
//
// Parameters:
//   RESET_PC      PC loaded on reset.
//   IMEM_LAT_MIN  Minimum cycles from imem_req to imem_rvalid. It documents
//                 the memory and has no effect on the logic.
//
// Ports:
//   clk            in   1   clock; all state changes on the rising edge
//   rst_n          in   1   asynchronous active-low reset
//   branch_taken   in   1   redirect request, valid for one cycle
//   branch_target  in   64  redirect address; bits [1:0] are ignored
//   stall          in   1   downstream hold; output buffer not consumed
//   imem_req       out  1   one-cycle fetch request pulse
//   imem_addr      out  64  fetch address, valid while imem_req=1
//   imem_rvalid    in   1   fetch response valid
//   imem_rdata     in   32  fetch response instruction word
//   if_valid       out  1   output buffer holds an instruction
//   if_pc          out  64  PC of the buffered instruction
//   if_instr       out  32  buffered instruction word
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          IMEM_LAT_MIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_ISSUE,
    S_WAIT,
    S_SKID,
    S_DRAIN
  } state_t;

  // The memory latency is a property of the attached memory only; this
  // block simply reacts to imem_rvalid whenever it comes.
  if (IMEM_LAT_MIN < 1) begin : g_lat_note
  end

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_imem_req;
  logic [63:0] r_imem_addr;
  logic        r_if_valid;
  logic [63:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic [63:0] r_skid_pc;
  logic [31:0] r_skid_instr;

  logic [63:0] w_target;
  logic [63:0] w_pc_inc;
  logic        w_buf_free;

  // Instructions are word aligned, so the low two target bits are dropped.
  assign w_target   = branch_target & ~64'h3;
  // Natural 64-bit wrap: ...FFFC + 4 = 0.
  assign w_pc_inc   = r_pc + 64'd4;
  // The buffer can take a new word if it is empty or being consumed now.
  assign w_buf_free = !r_if_valid || !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= 64'h0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 64'h0;
      r_if_instr   <= 32'h0;
      r_skid_pc    <= 64'h0;
      r_skid_instr <= 32'h0;
    end else begin
      // imem_req is registered: it is raised only on the edge entering
      // ISSUE, so it is high for exactly the one ISSUE cycle.
      r_imem_req <= 1'b0;

      // Output buffer default: a redirect or a consume empties it, a stall
      // holds it. Loads below override this (the redirect cases never load).
      if (branch_taken || !stall) begin
        r_if_valid <= 1'b0;
      end

      case (r_state)
        S_BOOT: begin
          // Any response arriving here belongs to a fetch abandoned by reset.
          r_state     <= S_ISSUE;
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
        end

        S_ISSUE: begin
          if (branch_taken) begin
            // The request just sent still returns; DRAIN swallows it.
            r_pc    <= w_target;
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (branch_taken) begin
            r_pc <= w_target;
            if (imem_rvalid) begin
              // Stale word dropped in the same cycle; refetch right away.
              r_state     <= S_ISSUE;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_target;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (imem_rvalid) begin
            r_pc <= w_pc_inc;
            if (w_buf_free) begin
              r_if_valid  <= 1'b1;
              r_if_pc     <= r_pc;
              r_if_instr  <= imem_rdata;
              r_state     <= S_ISSUE;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_pc_inc;
            end else begin
              // Buffer full and held: park the word, stop fetching.
              r_skid_pc    <= r_pc;
              r_skid_instr <= imem_rdata;
              r_state      <= S_SKID;
            end
          end
        end

        S_SKID: begin
          if (branch_taken) begin
            r_skid_pc    <= 64'h0;
            r_skid_instr <= 32'h0;
            r_pc         <= w_target;
            r_state      <= S_ISSUE;
            r_imem_req   <= 1'b1;
            r_imem_addr  <= w_target;
          end else if (!stall) begin
            // Buffer is consumed on this edge, so the skid word moves up.
            r_if_valid  <= 1'b1;
            r_if_pc     <= r_skid_pc;
            r_if_instr  <= r_skid_instr;
            r_state     <= S_ISSUE;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
          end
        end

        S_DRAIN: begin
          if (branch_taken) begin
            r_pc <= w_target;
          end
          // Leave once the stale response is swallowed. If a new redirect
          // lands on that same cycle, the response is still gone, so we
          // proceed to fetch the newest target instead of waiting forever.
          if (imem_rvalid) begin
            r_state     <= S_ISSUE;
            r_imem_req  <= 1'b1;
            r_imem_addr <= branch_taken ? w_target : r_pc;
          end
        end

        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed cycle-exact scenarios followed by a randomized run. In the
// randomized run a memory model answers each request after 1..3 cycles with
// a word derived from its address, and the delivered instruction stream is
// checked against the program-order rule: consecutive words at +4, restarted
// at the aligned target after every redirect, each carrying its own word.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  int n_checks = 0;
  int n_pass   = 0;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory at a given address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ {a[61:32], 2'b00} ^ 32'h5EED_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Randomized-phase state
  logic [63:0] exp_pc;
  logic        pending;
  logic [63:0] m_addr;
  int          m_rem;
  int          n_delivered;
  logic        p_v, p_req, p_bt, p_st, p_rv;
  logic [63:0] p_pc, p_addr, p_tgt;
  logic [31:0] p_in;

  initial begin
    rst_n         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    stall         = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_req",    64'(imem_req), 64'd0);
    check("rst_addr",   imem_addr,     64'd0);
    check("rst_valid",  64'(if_valid), 64'd0);
    check("rst_pc",     if_pc,         64'd0);
    check("rst_instr",  64'(if_instr), 64'd0);

    // ---------------- basic fetch, latency 1 ----------------
    rst_n = 1'b1;                                   // cycle 0: BOOT
    check("boot_req", 64'(imem_req), 64'd0);
    tick();                                         // cycle 1
    check("c1_req",  64'(imem_req), 64'd1);
    check("c1_addr", imem_addr,     64'h0);
    tick();                                         // cycle 2
    check("c2_req", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h0);
    tick(); imem_rvalid = 1'b0;                     // cycle 3
    check("c3_valid", 64'(if_valid), 64'd1);
    check("c3_pc",    if_pc,         64'h0);
    check("c3_instr", 64'(if_instr), 64'(mem_word(64'h0)));
    check("c3_req",   64'(imem_req), 64'd1);
    check("c3_addr",  imem_addr,     64'h4);
    tick();                                         // cycle 4
    check("c4_valid", 64'(if_valid), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h4);
    tick(); imem_rvalid = 1'b0;                     // cycle 5
    check("c5_valid", 64'(if_valid), 64'd1);
    check("c5_pc",    if_pc,         64'h4);
    check("c5_addr",  imem_addr,     64'h8);
    tick();                                         // cycle 6
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h8);
    stall = 1'b1;

    // ---------------- stall across two responses ----------------
    tick(); imem_rvalid = 1'b0;                     // cycle 7
    check("c7_valid", 64'(if_valid), 64'd1);
    check("c7_pc",    if_pc,         64'h8);
    check("c7_addr",  imem_addr,     64'hC);
    tick();                                         // cycle 8
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'hC);
    tick(); imem_rvalid = 1'b0;                     // cycle 9: skid
    check("skid_req1",  64'(imem_req), 64'd0);
    check("skid_hold1", if_pc,         64'h8);
    check("skid_val1",  64'(if_valid), 64'd1);
    tick();                                         // cycle 10
    check("skid_req2",  64'(imem_req), 64'd0);
    check("skid_hold2", 64'(if_instr), 64'(mem_word(64'h8)));
    stall = 1'b0;
    tick();                                         // cycle 11
    check("skid_out_pc",    if_pc,         64'hC);
    check("skid_out_instr", 64'(if_instr), 64'(mem_word(64'hC)));
    check("skid_out_req",   64'(imem_req), 64'd1);
    check("skid_out_addr",  imem_addr,     64'h10);

    // ---------------- redirect in ISSUE ----------------
    branch_taken = 1'b1; branch_target = 64'h1000;
    tick(); branch_taken = 1'b0;                    // cycle 12: DRAIN
    check("br_flush", 64'(if_valid), 64'd0);
    check("br_noreq", 64'(imem_req), 64'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h10);
    tick(); imem_rvalid = 1'b0;                     // cycle 13
    check("br_drop",  64'(if_valid), 64'd0);
    check("br_req",   64'(imem_req), 64'd1);
    check("br_addr",  imem_addr,     64'h1000);
    tick();                                         // cycle 14
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h1000);
    tick(); imem_rvalid = 1'b0;                     // cycle 15
    check("br_first_pc", if_pc, 64'h1000);
    check("br_first_instr", 64'(if_instr), 64'(mem_word(64'h1000)));

    // ---------------- redirect while stalled with skid full ----------------
    stall = 1'b1;
    tick();                                         // cycle 16
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h1004);
    tick(); imem_rvalid = 1'b0;                     // cycle 17: skid full
    check("bs_hold", if_pc, 64'h1000);
    branch_taken = 1'b1; branch_target = 64'h2003;
    tick(); branch_taken = 1'b0; stall = 1'b0;      // cycle 18
    check("bs_flush", 64'(if_valid), 64'd0);
    check("bs_req",   64'(imem_req), 64'd1);
    check("bs_addr",  imem_addr,     64'h2000);
    tick();                                         // cycle 19
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h2000);
    tick(); imem_rvalid = 1'b0;                     // cycle 20
    check("bs_next_pc",    if_pc,         64'h2000);
    check("bs_next_instr", 64'(if_instr), 64'(mem_word(64'h2000)));

    // ---------------- PC wrap ----------------
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); branch_taken = 1'b0;                    // cycle 21: DRAIN
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h2004);
    tick(); imem_rvalid = 1'b0;                     // cycle 22
    check("wrap_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();                                         // cycle 23
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'hFFFF_FFFF_FFFF_FFFC);
    tick(); imem_rvalid = 1'b0;                     // cycle 24
    check("wrap_pc",   if_pc,         64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_req",  64'(imem_req), 64'd1);
    check("wrap_addr", imem_addr,     64'h0);

    // ---------------- reset during WAIT, late response ----------------
    tick();                                         // cycle 25: WAIT
    rst_n = 1'b0;
    #1;
    check("ar_req",   64'(imem_req), 64'd0);
    check("ar_valid", 64'(if_valid), 64'd0);
    check("ar_pc",    if_pc,         64'd0);
    tick();
    rst_n = 1'b1;                                   // BOOT
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); imem_rvalid = 1'b0;
    check("late_req",   64'(imem_req), 64'd1);
    check("late_addr",  imem_addr,     64'h0);
    check("late_valid", 64'(if_valid), 64'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = mem_word(64'h0);
    tick(); imem_rvalid = 1'b0;
    check("late_first_pc",    if_pc,         64'h0);
    check("late_first_instr", 64'(if_instr), 64'(mem_word(64'h0)));

    // ---------------- randomized run against the stream model ----------------
    exp_pc      = 64'h0;
    pending     = 1'b0;
    m_addr      = 64'h0;
    m_rem       = 0;
    n_delivered = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p_v    = if_valid;
      p_pc   = if_pc;
      p_in   = if_instr;
      p_req  = imem_req;
      p_addr = imem_addr;

      stall        = ($urandom_range(0, 9) < 4);
      branch_taken = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        branch_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        branch_target = {$urandom, $urandom};

      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pending) begin
        m_rem--;
        if (m_rem == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(m_addr);
        end
      end
      p_bt  = branch_taken;
      p_tgt = branch_target;
      p_st  = stall;
      p_rv  = imem_rvalid;

      tick();

      if (p_rv) pending = 1'b0;
      if (p_req) begin
        check("rnd_addr_align", p_addr & 64'h3, 64'h0);
        check("rnd_req_pulse",  64'(imem_req),  64'd0);
        pending = 1'b1;
        m_addr  = p_addr;
        m_rem   = $urandom_range(1, 3);
      end
      if (imem_req) check("rnd_one_outstanding", 64'(pending), 64'd0);

      if (p_bt) begin
        check("rnd_br_flush", 64'(if_valid), 64'd0);
        exp_pc = p_tgt & ~64'h3;
      end else if (p_v && !p_st) begin
        check("rnd_order_pc", p_pc,      exp_pc);
        check("rnd_word",     64'(p_in), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        n_delivered++;
      end else if (p_v && p_st) begin
        check("rnd_hold_valid", 64'(if_valid), 64'd1);
        check("rnd_hold_pc",    if_pc,         p_pc);
        check("rnd_hold_instr", 64'(if_instr), 64'(p_in));
      end
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    imem_rvalid  = 1'b0;
    check("rnd_progress", 64'(n_delivered >= 100), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, sets the PC value loaded on reset.
REQ-002 Parameter IMEM_LAT_MIN, default 1, is the minimum cycles from imem_req to imem_rvalid; it is documentation only and has no logic effect.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 branch_taken  input  1  redirect request from the branch unit; single-cycle qualifier.
REQ-006 branch_target  input  64  redirect address (PC + offset<<2) from the branch target adder.
REQ-007 stall  input  1  downstream IF/ID hold; output buffer not consumed while high.
REQ-008 imem_req  output  1  one-cycle request pulse to instruction memory.
REQ-009 imem_addr  output  64  fetch address, valid when imem_req=1.
REQ-010 imem_rvalid  input  1  response valid; at most one request outstanding.
REQ-011 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-012 if_valid  output  1  output buffer holds a valid instruction.
REQ-013 if_pc  output  64  PC of the buffered instruction.
REQ-014 if_instr  output  32  buffered instruction word.

Function
REQ-015 The FSM states SHALL be BOOT, ISSUE, WAIT, SKID and DRAIN.
REQ-016 BOOT: imem_req=0 for one cycle after reset release, then ISSUE.
REQ-017 ISSUE: imem_req=1 and imem_addr=pc for exactly one cycle, then WAIT; with branch_taken, pc<=target and go to DRAIN.
REQ-018 WAIT, rvalid with no redirect and buffer free (!if_valid or !stall): buffer<={pc,rdata}, if_valid<=1, pc<=pc+4, go to ISSUE.
REQ-019 WAIT, rvalid with no redirect and buffer full and stall: skid<={pc,rdata}, pc<=pc+4, go to SKID.
REQ-020 WAIT, branch_taken with rvalid: discard rdata, pc<=target, go to ISSUE; branch_taken without rvalid: pc<=target, go to DRAIN.
REQ-021 SKID: imem_req=0; when !stall, move skid to buffer and go to ISSUE; with branch_taken, discard skid, pc<=target, go to ISSUE.
REQ-022 DRAIN: imem_req=0; the rvalid response is discarded, then go to ISSUE; a further branch_taken in DRAIN updates pc and stays in DRAIN.
REQ-023 branch_taken SHALL clear if_valid on the next edge in every state, taking precedence over stall and over any buffer load.
REQ-024 With no load and !stall, if_valid<=0; with stall, buffer contents are held unchanged.
REQ-025 pc+4 SHALL wrap modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC+4 gives 0.
REQ-026 Loaded targets SHALL have bits [1:0] forced to 0.
REQ-027 imem_rvalid in BOOT, ISSUE or SKID SHALL be ignored.
REQ-028 Fetch-to-if_valid latency SHALL be the memory latency +1 cycle; steady-state throughput is one instruction per (latency+1) cycles.

Reset
REQ-029 rst_n low SHALL immediately force state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, skid cleared.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding fetch; a late rvalid after release, during BOOT, is ignored.

Verification
REQ-031 Reset release, memory latency 1, no stall -> imem_req at addr 0,4,8 on cycles 1,3,5; if_valid with if_pc 0,4,8 on cycles 3,5,7.
REQ-032 stall held high across two rvalids -> first word held in the buffer, second in skid, no third imem_req until stall drops; then both delivered in order.
REQ-033 branch_taken, target 0x1000, in the ISSUE cycle of addr 0x8 -> next rvalid discarded, next imem_addr=0x1000, if_valid=0 on the following cycle.
REQ-034 branch_taken with stall=1 and buffer full -> if_valid=0 next cycle, skid discarded, fetch from target.
REQ-035 pc=0xFFFF_FFFF_FFFF_FFFC fetch completes -> next imem_addr=0x0.
REQ-036 rst_n pulsed low during WAIT, then rvalid arrives during BOOT -> rvalid ignored, first imem_addr=RESET_PC.
